// File: rtl/morph_pkg.sv
// Shared types and constants for the 3x3 morphology frame sequencer.
package morph_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_OUT   = 3'd4,
        ST_DONE  = 3'd5
    } morph_state_t;

    localparam logic MODE_MIN = 1'b0;
    localparam logic MODE_MAX = 1'b1;

    // Window element indices, raster order, element 0 = top-left.
    localparam int unsigned WIN_N    = 9;
    localparam int unsigned WIN_COLS = 3;
    localparam int unsigned WIN_TR   = 2;
    localparam int unsigned WIN_MR   = 5;
    localparam int unsigned WIN_BR   = 8;

endpackage

// File: rtl/morph_line_buffer.sv
// Line storage with one write port and a registered read port; contents are not reset.
module morph_line_buffer #(
    parameter int unsigned DEPTH = 640,
    parameter int unsigned DW    = 20,
    parameter int unsigned AW    = 10
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/morph_window_sequencer.sv
// Frame controller: builds 3x3 windows from a raster pixel stream, runs one
// filter-core transaction per interior pixel and streams the results out.
module morph_window_sequencer
    import morph_pkg::*;
#(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned IMG_W = 640,
    parameter int unsigned IMG_H = 480
) (
    input  logic                   iClk,
    input  logic                   iRst,
    input  logic                   iStart,
    input  logic                   iMode,
    input  logic [WIDTH-1:0]       iData,
    input  logic                   iValid,
    output logic                   oReady,
    output logic [WIDTH-1:0]       oData,
    output logic                   oValid,
    input  logic                   iReady,
    output logic                   oFrameDone,
    output logic [WIDTH*WIN_N-1:0] oFiltWin,
    output logic                   oFiltMode,
    output logic                   oFiltStart,
    input  logic [WIDTH-1:0]       iFiltValue,
    input  logic                   iFiltDone
);

    localparam int unsigned CW  = $clog2(IMG_W);
    localparam int unsigned RW  = $clog2(IMG_H + 1);
    localparam int unsigned LBW = 2 * WIDTH;

    morph_state_t           r_state;
    logic [CW-1:0]          r_col;
    logic [RW-1:0]          r_row;
    logic                   r_mode;
    logic                   r_last;
    logic [WIDTH*WIN_N-1:0] r_win;
    logic [WIDTH-1:0]       r_out_data;
    logic                   r_ready;
    logic                   r_valid;
    logic                   r_frame_done;
    logic                   r_filt_start;

    logic                   w_accept;
    logic                   w_col_wrap;
    logic                   w_win_done;
    logic [CW-1:0]          w_col_next;
    logic [LBW-1:0]         w_lb_rdata;
    logic [LBW-1:0]         w_lb_wdata;
    logic [WIDTH*WIN_N-1:0] w_win_shift;

    assign w_accept   = (r_state == ST_FILL) && iValid;
    assign w_col_wrap = (r_col == CW'(IMG_W - 1));
    assign w_win_done = (r_row >= RW'(2)) && (r_col >= CW'(2));
    // Line buffer word: upper half = two rows up, lower half = one row up.
    assign w_lb_wdata = {w_lb_rdata[WIDTH-1:0], iData};

    // Read address runs one accept ahead so the registered read is ready on the next accept.
    always_comb begin
        w_col_next = r_col;
        if (r_state == ST_IDLE) begin
            w_col_next = '0;
        end else if (w_accept) begin
            w_col_next = w_col_wrap ? '0 : r_col + CW'(1);
        end
    end

    always_comb begin
        w_win_shift = r_win;
        for (int r = 0; r < 3; r++) begin
            w_win_shift[(r*WIN_COLS+0)*WIDTH +: WIDTH] = r_win[(r*WIN_COLS+1)*WIDTH +: WIDTH];
            w_win_shift[(r*WIN_COLS+1)*WIDTH +: WIDTH] = r_win[(r*WIN_COLS+2)*WIDTH +: WIDTH];
        end
        w_win_shift[WIN_TR*WIDTH +: WIDTH] = w_lb_rdata[LBW-1:WIDTH];
        w_win_shift[WIN_MR*WIDTH +: WIDTH] = w_lb_rdata[WIDTH-1:0];
        w_win_shift[WIN_BR*WIDTH +: WIDTH] = iData;
    end

    morph_line_buffer #(
        .DEPTH (IMG_W),
        .DW    (LBW),
        .AW    (CW)
    ) u_line_buffer (
        .i_clk   (iClk),
        .i_we    (w_accept),
        .i_waddr (r_col),
        .i_wdata (w_lb_wdata),
        .i_raddr (w_col_next),
        .o_rdata (w_lb_rdata)
    );

    // Sequencer FSM; every output is a register updated alongside the state.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            r_state      <= ST_IDLE;
            r_col        <= '0;
            r_row        <= '0;
            r_mode       <= MODE_MIN;
            r_last       <= 1'b0;
            r_win        <= '0;
            r_out_data   <= '0;
            r_ready      <= 1'b0;
            r_valid      <= 1'b0;
            r_frame_done <= 1'b0;
            r_filt_start <= 1'b0;
        end else begin
            r_filt_start <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (iStart) begin
                        r_mode  <= iMode;
                        r_col   <= '0;
                        r_row   <= '0;
                        r_ready <= 1'b1;
                        r_state <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (w_accept) begin
                        r_win  <= w_win_shift;
                        r_col  <= w_col_next;
                        r_last <= (r_row == RW'(IMG_H - 1)) && w_col_wrap;
                        if (w_col_wrap) begin
                            r_row <= r_row + RW'(1);
                        end
                        if (w_win_done) begin
                            r_ready      <= 1'b0;
                            r_filt_start <= 1'b1;
                            r_state      <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (iFiltDone) begin
                        r_out_data <= iFiltValue;
                        r_valid    <= 1'b1;
                        r_state    <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (iReady) begin
                        r_valid <= 1'b0;
                        if (r_last) begin
                            r_frame_done <= 1'b1;
                            r_state      <= ST_DONE;
                        end else begin
                            r_ready <= 1'b1;
                            r_state <= ST_FILL;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign oReady     = r_ready;
    assign oData      = r_out_data;
    assign oValid     = r_valid;
    assign oFrameDone = r_frame_done;
    assign oFiltWin   = r_win;
    assign oFiltMode  = r_mode;
    assign oFiltStart = r_filt_start;

endmodule

// File: tb/tb_morph_window_sequencer.sv
// Bench for morph_window_sequencer: a 4x4 and a 3x3 instance, each driven by a
// behavioral min/max filter core with programmable latency.
module tb_morph_window_sequencer;
    import morph_pkg::*;

    localparam int unsigned WIDTH = 10;
    localparam int unsigned WINW  = WIDTH * WIN_N;

    logic             iClk = 1'b0;
    logic             iRst;
    logic             s_start[2], s_mode[2], s_ivalid[2], s_iready[2], s_fdone[2];
    logic [WIDTH-1:0] s_idata[2], s_fval[2], s_odata[2];
    logic             s_oready[2], s_ovalid[2], s_frame_done[2], s_fmode[2], s_fstart[2];
    logic [WINW-1:0]  s_fwin[2];

    int               n_checks = 0;
    int               n_err    = 0;
    int               f_cnt[2];
    int               f_lat[2];
    logic [WIDTH-1:0] f_val[2];
    int               q_exp[$];

    typedef struct {
        int   d;
        logic mode;
        int   base;
        int   step;
        int   stall;
        int   lat;
        bit   restart;
        int   n_out;
        int   e0, e1, e2, e3;
        int   cyc;
    } vec_t;

    vec_t vecs[5];

    morph_window_sequencer #(.WIDTH(WIDTH), .IMG_W(4), .IMG_H(4)) u_dut4 (
        .iClk(iClk), .iRst(iRst), .iStart(s_start[0]), .iMode(s_mode[0]),
        .iData(s_idata[0]), .iValid(s_ivalid[0]), .oReady(s_oready[0]),
        .oData(s_odata[0]), .oValid(s_ovalid[0]), .iReady(s_iready[0]),
        .oFrameDone(s_frame_done[0]), .oFiltWin(s_fwin[0]), .oFiltMode(s_fmode[0]),
        .oFiltStart(s_fstart[0]), .iFiltValue(s_fval[0]), .iFiltDone(s_fdone[0])
    );

    morph_window_sequencer #(.WIDTH(WIDTH), .IMG_W(3), .IMG_H(3)) u_dut3 (
        .iClk(iClk), .iRst(iRst), .iStart(s_start[1]), .iMode(s_mode[1]),
        .iData(s_idata[1]), .iValid(s_ivalid[1]), .oReady(s_oready[1]),
        .oData(s_odata[1]), .oValid(s_ovalid[1]), .iReady(s_iready[1]),
        .oFrameDone(s_frame_done[1]), .oFiltWin(s_fwin[1]), .oFiltMode(s_fmode[1]),
        .oFiltStart(s_fstart[1]), .iFiltValue(s_fval[1]), .iFiltDone(s_fdone[1])
    );

    always #5 iClk = ~iClk;

    function automatic logic [WIDTH-1:0] win_reduce(input logic [WINW-1:0] w, input logic m);
        logic [WIDTH-1:0] r, e;
        r = w[WIDTH-1:0];
        for (int k = 1; k < int'(WIN_N); k++) begin
            e = w[k*WIDTH +: WIDTH];
            if (m ? (e > r) : (e < r)) r = e;
        end
        return r;
    endfunction

    // Filter core model: done pulses L cycles after the cycle start is high.
    always @(negedge iClk) begin
        for (int d = 0; d < 2; d++) begin
            if (!iRst) begin
                f_cnt[d]   = 0;
                s_fdone[d] = 1'b0;
                s_fval[d]  = '0;
            end else if (s_fstart[d]) begin
                f_cnt[d]   = f_lat[d];
                f_val[d]   = win_reduce(s_fwin[d], s_fmode[d]);
                s_fdone[d] = 1'b0;
            end else if (f_cnt[d] > 0) begin
                f_cnt[d]   = f_cnt[d] - 1;
                s_fdone[d] = (f_cnt[d] == 0);
                if (f_cnt[d] == 0) s_fval[d] = f_val[d];
            end else begin
                s_fdone[d] = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_reset(input int d, input string tag);
        chk({tag, "_oReady"},     int'(s_oready[d]),     0);
        chk({tag, "_oValid"},     int'(s_ovalid[d]),     0);
        chk({tag, "_oData"},      int'(s_odata[d]),      0);
        chk({tag, "_oFrameDone"}, int'(s_frame_done[d]), 0);
        chk({tag, "_oFiltStart"}, int'(s_fstart[d]),     0);
        chk({tag, "_oFiltWin"},   int'(s_fwin[d] != '0), 0);
        chk({tag, "_oFiltMode"},  int'(s_fmode[d]),      0);
    endtask

    task automatic run_frame(input vec_t v, input string name);
        int               w, n, pi, cyc, scnt, got;
        bit               held, done;
        logic [WIDTH-1:0] hold_val;
        int               pix[16];
        int               ev[4];
        w = (v.d == 0) ? 4 : 3;
        n = w * w;
        for (int i = 0; i < n; i++) pix[i] = v.base + v.step * i;
        ev = '{v.e0, v.e1, v.e2, v.e3};
        q_exp.delete();
        for (int k = 0; k < v.n_out; k++) q_exp.push_back(ev[k]);
        @(negedge iClk);
        f_lat[v.d]    = v.lat;
        s_start[v.d]  = 1'b1;
        s_mode[v.d]   = v.mode;
        s_ivalid[v.d] = 1'b1;
        s_idata[v.d]  = WIDTH'(pix[0]);
        s_iready[v.d] = 1'b1;
        pi = 0; cyc = 0; scnt = 0; held = 0; done = 0; hold_val = '0;
        while (!done && cyc < 400) begin
            @(negedge iClk);
            cyc++;
            s_start[v.d]  = v.restart && (cyc == 10);
            s_mode[v.d]   = ~v.mode;
            s_ivalid[v.d] = (pi < n);
            if (pi < n) s_idata[v.d] = WIDTH'(pix[pi]);
            if (s_oready[v.d] && pi < n) pi++;
            if (s_fstart[v.d]) chk({name, "_filt_mode"}, int'(s_fmode[v.d]), int'(v.mode));
            if (held) begin
                chk({name, "_stall_valid"}, int'(s_ovalid[v.d]), 1);
                chk({name, "_stall_data"},  int'(s_odata[v.d]),  int'(hold_val));
            end
            if (s_ovalid[v.d]) begin
                if (!held) begin
                    held     = 1;
                    hold_val = s_odata[v.d];
                    scnt     = 0;
                end
                if (scnt < v.stall) begin
                    s_iready[v.d] = 1'b0;
                    scnt++;
                end else begin
                    s_iready[v.d] = 1'b1;
                    held = 0;
                    if (q_exp.size() == 0) begin
                        chk({name, "_extra_output"}, int'(s_odata[v.d]), -1);
                    end else begin
                        got = q_exp.pop_front();
                        chk({name, "_out"}, int'(s_odata[v.d]), got);
                    end
                end
            end else begin
                s_iready[v.d] = 1'b1;
            end
            if (s_frame_done[v.d]) begin
                chk({name, "_done_cycle"}, cyc, v.cyc);
                chk({name, "_missing_outputs"}, q_exp.size(), 0);
                done = 1;
            end
        end
        if (!done) chk({name, "_timeout"}, 0, 1);
        s_start[v.d]  = 1'b0;
        s_ivalid[v.d] = 1'b0;
        @(negedge iClk);
        chk({name, "_done_pulse_width"}, int'(s_frame_done[0] | s_frame_done[1]), 0);
        chk({name, "_idle_ready"}, int'(s_oready[v.d]), 0);
    endtask

    // Reset asserted while instance 0 waits on the filter core.
    task automatic abort_in_wait();
        int pi;
        bit hit;
        @(negedge iClk);
        f_lat[0]    = 2;
        s_start[0]  = 1'b1;
        s_mode[0]   = MODE_MAX;
        s_ivalid[0] = 1'b1;
        s_idata[0]  = '0;
        s_iready[0] = 1'b1;
        pi = 0;
        hit = 0;
        for (int c = 0; c < 100 && !hit; c++) begin
            @(negedge iClk);
            s_start[0]  = 1'b0;
            s_ivalid[0] = (pi < 16);
            s_idata[0]  = WIDTH'(pi);
            if (s_oready[0] && pi < 16) pi++;
            if (s_fstart[0]) begin
                @(negedge iClk);
                chk("abort_mode_before_reset", int'(s_fmode[0]), 1);
                iRst = 1'b0;
                #1;
                chk_reset(0, "abort");
                hit = 1;
            end
        end
        if (!hit) chk("abort_reach_wait", 0, 1);
        s_ivalid[0] = 1'b0;
        repeat (3) @(negedge iClk);
        chk("abort_held_idle_ready", int'(s_oready[0]), 0);
        iRst = 1'b1;
        @(negedge iClk);
        chk("abort_idle_after_release", int'(s_oready[0]), 0);
    endtask

    initial begin
        vecs[0] = '{0, MODE_MIN, 0,  1, 0, 2, 1'b0, 4, 0,  1,  4,  5,  33};
        vecs[1] = '{0, MODE_MAX, 0,  1, 0, 2, 1'b0, 4, 10, 11, 14, 15, 33};
        vecs[2] = '{1, MODE_MIN, 9, -1, 0, 2, 1'b0, 1, 1,  0,  0,  0,  14};
        vecs[3] = '{0, MODE_MIN, 0,  1, 7, 2, 1'b0, 4, 0,  1,  4,  5,  61};
        vecs[4] = '{0, MODE_MIN, 0,  1, 0, 6, 1'b1, 4, 0,  1,  4,  5,  49};
        for (int d = 0; d < 2; d++) begin
            s_start[d]  = 1'b0;
            s_mode[d]   = 1'b0;
            s_ivalid[d] = 1'b0;
            s_iready[d] = 1'b1;
            s_idata[d]  = '0;
            f_lat[d]    = 2;
            f_val[d]    = '0;
        end
        iRst = 1'b0;
        repeat (3) @(negedge iClk);
        chk_reset(0, "por4");
        chk_reset(1, "por3");
        iRst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            run_frame(vecs[i], $sformatf("vec%0d", i));
        end
        abort_in_wait();
        run_frame(vecs[0], "post_reset");
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
